// File: rtl/calc_job_sequencer.sv
// Operand FIFO plus single-job sequencer for the a^3 + sqrt(b) calculator.
// Results leave in acceptance order with a 2-bit tag; a hung calculator yields an error result.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | waiting for a queued pair and a free output slot
// LAUNCH    | calc_start_o high for one cycle, operands held
// WAIT_BUSY | waiting up to 4 cycles for calc_busy_i to rise
// RUN       | calculator busy; bounded by RUN_TIMEOUT
module calc_job_sequencer #(
  parameter int DEPTH       = 4,
  parameter int RUN_TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [7:0]  in_a_bi,
  input  logic [7:0]  in_b_bi,
  output logic        calc_start_o,
  output logic [7:0]  calc_a_bo,
  output logic [7:0]  calc_b_bo,
  input  logic        calc_busy_i,
  input  logic [23:0] calc_y_bi,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [23:0] out_y_bo,
  output logic [1:0]  out_tag_bo,
  output logic        out_err_o,
  output logic        err_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (RUN_TIMEOUT < 4) ? 2 : $clog2(RUN_TIMEOUT + 1);
  localparam logic [CW-1:0] RUN_TC   = CW'(RUN_TIMEOUT);
  localparam logic [CW-1:0] WAIT_TC  = CW'(3);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT_BUSY, S_RUN} state_t;

  logic [17:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic [1:0]    tag_q;
  logic [17:0]   head;
  logic          push, pop, full, empty;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    a_q, a_d, b_q, b_d;
  logic [1:0]    job_tag_q, job_tag_d;
  logic          out_valid_q, out_valid_d;
  logic [23:0]   out_y_q, out_y_d;
  logic [1:0]    out_tag_q, out_tag_d;
  logic          out_err_q, out_err_d;
  logic          err_q, err_d;
  logic          done_ok, timeout;

  assign full       = (count_q == FULL_CNT);
  assign empty      = (count_q == '0);
  assign in_ready_o = rst_i && !full;
  assign push       = in_valid_i && in_ready_o;
  assign head       = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      tag_q    <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
        tag_q    <= tag_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage needs no reset: the pointers define what is valid.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= {tag_q, in_a_bi, in_b_bi};
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    job_tag_d   = job_tag_q;
    out_valid_d = out_valid_q;
    out_y_d     = out_y_q;
    out_tag_d   = out_tag_q;
    out_err_d   = out_err_q;
    err_d       = err_q;
    pop         = 1'b0;
    done_ok     = 1'b0;
    timeout     = 1'b0;

    if (out_valid_q && out_ready_i) out_valid_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // Gating on the registered valid also blocks the handshake cycle.
        if (!empty && !out_valid_q) begin
          pop       = 1'b1;
          job_tag_d = head[17:16];
          a_d       = head[15:8];
          b_d       = head[7:0];
          state_d   = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        cnt_d   = '0;
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (calc_busy_i) begin
          cnt_d   = '0;
          state_d = S_RUN;
        end else if (cnt_q == WAIT_TC) begin
          timeout = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RUN: begin
        if (!calc_busy_i)          done_ok = 1'b1;
        else if (cnt_q == RUN_TC)  timeout = 1'b1;
        else                       cnt_d   = cnt_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (done_ok || timeout) begin
      state_d     = S_IDLE;
      out_valid_d = 1'b1;
      out_y_d     = timeout ? 24'hFFFFFF : calc_y_bi;
      out_tag_d   = job_tag_q;
      out_err_d   = timeout;
      if (timeout) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      job_tag_q   <= '0;
      out_valid_q <= 1'b0;
      out_y_q     <= '0;
      out_tag_q   <= '0;
      out_err_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      job_tag_q   <= job_tag_d;
      out_valid_q <= out_valid_d;
      out_y_q     <= out_y_d;
      out_tag_q   <= out_tag_d;
      out_err_q   <= out_err_d;
      err_q       <= err_d;
    end
  end

  assign calc_start_o = (state_q == S_LAUNCH);
  assign calc_a_bo    = a_q;
  assign calc_b_bo    = b_q;
  assign out_valid_o  = out_valid_q;
  assign out_y_bo     = out_y_q;
  assign out_tag_bo   = out_tag_q;
  assign out_err_o    = out_err_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_calc_job_sequencer.sv
// Directed bench for calc_job_sequencer with a behavioural y = a^3 + sqrt(b) calculator.
module tb_calc_job_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [7:0]  in_a_bi = '0;
  logic [7:0]  in_b_bi = '0;
  logic        calc_start_o;
  logic [7:0]  calc_a_bo, calc_b_bo;
  logic        calc_busy_i = 1'b0;
  logic [23:0] calc_y_bi = '0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [23:0] out_y_bo;
  logic [1:0]  out_tag_bo;
  logic        out_err_o;
  logic        err_o;

  calc_job_sequencer #(.DEPTH(4), .RUN_TIMEOUT(255)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_a_bi(in_a_bi), .in_b_bi(in_b_bi),
    .calc_start_o(calc_start_o), .calc_a_bo(calc_a_bo), .calc_b_bo(calc_b_bo),
    .calc_busy_i(calc_busy_i), .calc_y_bi(calc_y_bi),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_y_bo(out_y_bo),
    .out_tag_bo(out_tag_bo), .out_err_o(out_err_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  int vecs = 0;
  int miscompares = 0;
  int mode = 0;        // 0 normal, 1 busy stuck high, 2 busy never rises
  int busy_len = 6;
  int rem = 0;
  int starts = 0;
  int accepts = 0;

  function automatic int isqrt(input int v);
    int r = 0;
    while ((r + 1) * (r + 1) <= v) r++;
    return r;
  endfunction

  always @(negedge clk_i) begin
    if (calc_start_o) begin
      calc_y_bi = 24'(int'(calc_a_bo) * int'(calc_a_bo) * int'(calc_a_bo) + isqrt(int'(calc_b_bo)));
      if (mode == 0) begin
        calc_busy_i = 1'b1;
        rem = busy_len;
      end else if (mode == 1) begin
        calc_busy_i = 1'b1;
      end
    end else if (mode == 0 && rem > 0) begin
      rem--;
      if (rem == 0) calc_busy_i = 1'b0;
    end
  end

  always @(posedge clk_i) begin
    if (calc_start_o) starts++;
    if (out_valid_o && out_ready_i) accepts++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready_o), 0);
    chk({tag, "_start_ab"}, {15'd0, calc_start_o, calc_a_bo, calc_b_bo}, 0);
    chk({tag, "_out_valid"}, 32'(out_valid_o), 0);
    chk({tag, "_out_y"}, 32'(out_y_bo), 0);
    chk({tag, "_tag_err"}, {28'd0, out_tag_bo, out_err_o, err_o}, 0);
  endtask

  task automatic do_reset();
    rst_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
    rem = 0; mode = 0; calc_busy_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
  endtask

  // Called at a negedge; returns at a negedge after the pair is accepted.
  task automatic push(input logic [7:0] a, input logic [7:0] b);
    int n = 0;
    in_a_bi = a; in_b_bi = b; in_valid_i = 1'b1;
    while (!in_ready_o && n < 300) begin
      @(negedge clk_i);
      n++;
    end
    if (!in_ready_o) begin
      chk("push_accept", 32'(in_ready_o), 1);
      in_valid_i = 1'b0;
    end else begin
      @(negedge clk_i);
      in_valid_i = 1'b0;
    end
  endtask

  task automatic get_result(output logic [23:0] y, output logic [1:0] t, output logic e, output int waited);
    waited = 0;
    while (!out_valid_o && waited < 600) begin
      @(negedge clk_i);
      waited++;
    end
    if (!out_valid_o) chk("result_wait", 32'(out_valid_o), 1);
    y = out_y_bo; t = out_tag_bo; e = out_err_o;
    out_ready_i = 1'b1;
    @(negedge clk_i);
    out_ready_i = 1'b0;
  endtask

  int exp_y [5] = '{10, 30, 68, 130, 222};
  int exp_t [5] = '{1, 2, 3, 0, 1};

  initial begin
    logic [23:0] y;
    logic [1:0]  t;
    logic        e;
    int          w, s0, a0;

    // reset values
    repeat (2) @(negedge clk_i);
    chk_reset_state("reset");
    rst_i = 1'b1;
    @(negedge clk_i);
    chk("ready_after_reset", 32'(in_ready_o), 1);

    // single job
    out_ready_i = 1'b1; busy_len = 6; s0 = starts;
    push(8'd2, 8'd16);
    get_result(y, t, e, w);
    chk("single_y", 32'(y), 12);
    chk("single_tag_err", {29'd0, t, e}, 0);
    chk("single_starts", 32'(starts - s0), 1);
    chk("single_err_o", 32'(err_o), 0);

    // back-to-back with stalled output
    do_reset(); s0 = starts;
    push(8'd3, 8'd81); push(8'd1, 8'd0); push(8'd4, 8'd4);
    w = 0;
    while (!out_valid_o && w < 100) begin @(negedge clk_i); w++; end
    chk("b2b_first_y", 32'(out_y_bo), 36);
    chk("b2b_first_tag", 32'(out_tag_bo), 0);
    repeat (20) @(negedge clk_i);
    chk("b2b_held_valid", 32'(out_valid_o), 1);
    chk("b2b_held_y", 32'(out_y_bo), 36);
    chk("b2b_no_second_start", 32'(starts - s0), 1);
    out_ready_i = 1'b1;
    @(negedge clk_i);
    out_ready_i = 1'b0;
    chk("b2b_no_launch_on_accept", 32'(calc_start_o), 0);
    @(negedge clk_i);
    chk("b2b_launch_after", 32'(calc_start_o), 1);
    get_result(y, t, e, w);
    chk("b2b_second", {6'd0, y, t}, {6'd0, 24'd1, 2'd1});
    get_result(y, t, e, w);
    chk("b2b_third", {6'd0, y, t}, {6'd0, 24'd66, 2'd2});
    chk("b2b_starts", 32'(starts - s0), 3);

    // full FIFO
    do_reset(); busy_len = 3;
    push(8'd1, 8'd1); push(8'd2, 8'd4); push(8'd3, 8'd9); push(8'd4, 8'd16); push(8'd5, 8'd25);
    chk("full_ready_low", 32'(in_ready_o), 0);
    in_a_bi = 8'd6; in_b_bi = 8'd36; in_valid_i = 1'b1;
    repeat (10) @(negedge clk_i);
    chk("full_sixth_refused", 32'(in_ready_o), 0);
    chk("full_first_valid", 32'(out_valid_o), 1);
    get_result(y, t, e, w);
    chk("full_first", {6'd0, y, t}, {6'd0, 24'd2, 2'd0});
    w = 0;
    while (!in_ready_o && w < 20) begin @(negedge clk_i); w++; end
    chk("full_sixth_ready", 32'(in_ready_o), 1);
    @(negedge clk_i);
    in_valid_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      get_result(y, t, e, w);
      chk($sformatf("full_drain%0d", i), {5'd0, y, t, e}, {5'd0, 24'(exp_y[i]), 2'(exp_t[i]), 1'b0});
    end

    // run timeout with busy stuck high, then recovery
    do_reset(); mode = 1;
    push(8'd7, 8'd0);
    get_result(y, t, e, w);
    chk("rto_y", 32'(y), 32'hFFFFFF);
    chk("rto_tag_err", {29'd0, t, e}, {29'd0, 2'd0, 1'b1});
    chk("rto_err_o", 32'(err_o), 1);
    chk("rto_latency", 32'(w >= 250 && w <= 270), 1);
    mode = 0; calc_busy_i = 1'b0; busy_len = 5;
    push(8'd3, 8'd9);
    get_result(y, t, e, w);
    chk("rto_recover", {5'd0, y, t, e}, {5'd0, 24'd30, 2'd1, 1'b0});
    chk("rto_err_sticky", 32'(err_o), 1);

    // busy never rises
    do_reset();
    chk("nob_err_cleared", 32'(err_o), 0);
    mode = 2;
    push(8'd2, 8'd2);
    get_result(y, t, e, w);
    chk("nob_y", 32'(y), 32'hFFFFFF);
    chk("nob_err", {30'd0, e, err_o}, 3);
    chk("nob_latency", 32'(w >= 5 && w <= 8), 1);
    mode = 0;
    push(8'd2, 8'd16);
    get_result(y, t, e, w);
    chk("nob_recover", {5'd0, y, t, e}, {5'd0, 24'd12, 2'd1, 1'b0});

    // reset in the middle of RUN with two jobs queued
    do_reset(); busy_len = 20; out_ready_i = 1'b1;
    push(8'd1, 8'd1); push(8'd2, 8'd4); push(8'd3, 8'd9);
    repeat (6) @(negedge clk_i);
    a0 = accepts;
    rst_i = 1'b0;
    @(negedge clk_i);
    chk_reset_state("midrst");
    rem = 0; calc_busy_i = 1'b0;
    rst_i = 1'b1;
    repeat (40) @(negedge clk_i);
    chk("midrst_no_results", 32'(accepts - a0), 0);
    push(8'd4, 8'd4);
    get_result(y, t, e, w);
    chk("midrst_next", {5'd0, y, t, e}, {5'd0, 24'd66, 2'd0, 1'b0});

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule

// File: doc/calc_job_sequencer.md
CALC_JOB_SEQUENCER -- requirements
Module: calc_job_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, operand FIFO depth (power of two, 2..16).
REQ-002 SHALL have parameter RUN_TIMEOUT, default 255, max cycles calc_busy_i may stay high per job.
REQ-003 SHALL have port clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, synchronous, active-low.
REQ-005 SHALL have ports in_valid_i input 1, in_ready_o output 1, in_a_bi input 8, in_b_bi input 8: operand-pair valid/ready stream.
REQ-006 SHALL have ports calc_start_o output 1, calc_a_bo output 8, calc_b_bo output 8, calc_busy_i input 1, calc_y_bi input 24: link to downstream y = a^3 + sqrt(b) calculator.
REQ-007 SHALL have ports out_valid_o output 1, out_ready_i input 1, out_y_bo output 24, out_tag_bo output 2, out_err_o output 1: result valid/ready stream.
REQ-008 SHALL have port err_o  output  1  sticky timeout flag.

Function
REQ-009 SHALL accept an operand pair when in_valid_i && in_ready_o; in_ready_o = FIFO not full (no pass-through when full, even if popping that cycle).
REQ-010 SHALL tag each accepted pair with a 2-bit counter, +1 per accept, wrapping 3->0, tag stored in FIFO.
REQ-011 SHALL use FSM IDLE, LAUNCH, WAIT_BUSY, RUN; only one job in the calculator at a time.
REQ-012 IDLE: if FIFO non-empty and out_valid_o=0, SHALL pop head into calc_a_bo/calc_b_bo/tag regs and go LAUNCH; else stay.
REQ-013 LAUNCH: calc_start_o SHALL be 1 for exactly this one cycle; next state WAIT_BUSY.
REQ-014 calc_a_bo/calc_b_bo SHALL be held stable from LAUNCH until return to IDLE.
REQ-015 WAIT_BUSY: calc_busy_i=1 -> RUN; if busy not seen within 4 cycles of entering WAIT_BUSY -> timeout completion (REQ-018).
REQ-016 RUN: cycle counter from 0; calc_busy_i=0 -> capture calc_y_bi into out_y_bo, out_err_o=0, out_valid_o=1 next cycle, go IDLE.
REQ-017 RUN: counter reaching RUN_TIMEOUT with busy still 1 -> timeout completion.
REQ-018 Timeout completion SHALL load out_y_bo=24'hFFFFFF, out_err_o=1, out_valid_o=1, set err_o, go IDLE.
REQ-019 out_valid_o and out_y_bo/out_tag_bo/out_err_o SHALL hold until out_valid_o && out_ready_i; out_valid_o clears the following cycle.
REQ-020 Results SHALL leave in acceptance order; tags consecutive mod 4.
REQ-021 FIFO push and pop in the same cycle SHALL leave occupancy unchanged; pop on empty and push on full SHALL never occur.
REQ-022 Jobs from IDLE SHALL not launch while out_valid_o=1, including the cycle the output is being accepted (launch the cycle after).
REQ-023 err_o SHALL stay 1 until reset; operation continues normally after a timeout.

Reset
REQ-024 On rst_i=0 at a clock edge: FSM=IDLE, FIFO empty, tag counter 0, calc_start_o=0, calc_a_bo=calc_b_bo=0, out_valid_o=0, out_y_bo=0, out_tag_bo=0, out_err_o=0, err_o=0; in_ready_o=0 while rst_i=0, 1 first cycle after.
REQ-025 Reset mid-job (any state) SHALL discard FIFO contents and in-flight job; no result emitted for them.

Verification
REQ-026 Single job: a=2, b=16, out_ready_i=1, model busy 6 cycles -> one calc_start_o pulse, out_y_bo=12, out_tag_bo=0, out_err_o=0.
REQ-027 Back-to-back: push (3,81),(1,0),(4,4) with out_ready_i=0 for 20 cycles -> first result 36 tag 0 held, no second start until accepted; then 1 tag 1, 66 tag 2 in order.
REQ-028 Full FIFO: DEPTH=4, calc busy stuck low never raised... instead out_ready_i=0 -> after 1 job launched and 4 pushes, in_ready_o=0; 6th push refused until output accepted.
REQ-029 Timeout: calc_busy_i held 1 after start for 300 cycles -> at RUN_TIMEOUT result 24'hFFFFFF, out_err_o=1, err_o=1 sticky; next job with normal model returns correct y.
REQ-030 No-busy timeout: calc_busy_i never rises -> after 4 WAIT_BUSY cycles result 24'hFFFFFF, err_o=1.
REQ-031 Reset mid-RUN: assert rst_i=0 one cycle with 2 jobs queued -> all outputs at reset values, no results produced, next accepted pair tagged 0.
